// File: rtl/hcb_packet_sequencer.sv
// hcb_packet_sequencer: input side of the clause-evaluation chain.
// Splits each datapoint into PACKETS_NUM AXI-Stream beats. Each beat goes out on
// the shared x bus with a one-hot valid strobe. The last stage's partial_clause
// is returned through a valid/ready handshake. Only the last packet of the next
// datapoint is stalled while a result is still pending.
module hcb_packet_sequencer #(
    parameter int PACKETS_NUM            = 13,
    parameter int CLAUSE_NUM             = 200,
    parameter int C_S00_AXIS_TDATA_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              s00_axis_aresetn,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                              s00_axis_tvalid,
    input  logic                              s00_axis_tlast,
    output logic                              s00_axis_tready,
    output logic [C_S00_AXIS_TDATA_WIDTH-1:0] x,
    output logic [PACKETS_NUM-1:0]            valid,
    input  logic [CLAUSE_NUM-1:0]             partial_clause,
    output logic [CLAUSE_NUM-1:0]             clause,
    output logic                              clause_valid,
    input  logic                              clause_ready,
    output logic                              frame_err,
    output logic [31:0]                       dp_count
);

    localparam int IDX_W = (PACKETS_NUM > 1) ? $clog2(PACKETS_NUM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKETS_NUM - 1);
    localparam logic [PACKETS_NUM-1:0] ONE_HOT0 = PACKETS_NUM'(1);

    logic [IDX_W-1:0] pkt_idx;
    logic             is_last;
    logic             accept;
    logic             result_taken;

    assign is_last      = (pkt_idx == LAST_IDX);
    // Only registered state feeds tready, so there is no path from clause_ready.
    assign s00_axis_tready = s00_axis_aresetn & ~(is_last & clause_valid);
    assign accept       = s00_axis_tvalid & s00_axis_tready;
    assign result_taken = clause_valid & clause_ready;

    // The result comes straight from the final stage. It stays stable because
    // valid[last] cannot fire again until the pending result has been consumed.
    assign clause = partial_clause;

    // Beat capture, packet index tracking and framing checks.
    always_ff @(posedge clk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            pkt_idx   <= '0;
            x         <= '0;
            valid     <= '0;
            frame_err <= 1'b0;
        end else if (accept) begin
            x     <= s00_axis_tdata;
            valid <= ONE_HOT0 << pkt_idx;
            // An early tlast resynchronises to packet 0. Because of that, the
            // aborted datapoint never strobes the last stage.
            if (is_last || s00_axis_tlast)
                pkt_idx <= '0;
            else
                pkt_idx <= pkt_idx + 1'b1;
            if (is_last != s00_axis_tlast)
                frame_err <= 1'b1;
        end else begin
            valid <= '0;
        end
    end

    // Result handshake toward the class-sum stage, plus the completed-result count.
    always_ff @(posedge clk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            clause_valid <= 1'b0;
            dp_count     <= '0;
        end else begin
            if (valid[PACKETS_NUM-1])
                clause_valid <= 1'b1;
            else if (result_taken)
                clause_valid <= 1'b0;
            if (result_taken)
                dp_count <= dp_count + 32'd1;
        end
    end

endmodule
